// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the core MEM stage makes single-beat accesses and a DMA port makes
// word bursts that cannot be interrupted. A starve counter bounds how long the DMA waits.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LEN_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [31:0]      core_addr,
  input  logic [31:0]      core_wdata,
  input  logic [2:0]       core_funct3,
  output logic             core_gnt,
  output logic             core_stall,
  output logic             core_rvalid,
  output logic [31:0]      core_rdata,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [31:0]      dma_addr,
  input  logic [LEN_W-1:0] dma_len,
  input  logic [31:0]      dma_wdata,
  output logic             dma_gnt,
  output logic             dma_rvalid,
  output logic [31:0]      dma_rdata,
  output logic             dma_done,
  output logic             dma_err,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_funct3,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             we_q, we_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             dma_start;
  logic             dma_last;
  logic             starve_full;

  assign starve_full = (starve_q == SW'(STARVE_LIMIT));
  assign dma_last    = (beat_q == len_q);
  assign core_stall  = rst_n & core_req & ~core_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    len_d    = len_q;
    we_d     = we_q;
    starve_d = starve_q;
    unique case (state_q)
      StIdle: begin
        if (dma_start) begin
          addr_d = dma_addr + 32'd4;
          len_d  = dma_len;
          we_d   = dma_we;
          beat_d = LEN_W'(1);
          if (dma_len != '0) state_d = StBurst;
        end
      end
      StBurst: begin
        addr_d = addr_q + 32'd4;
        beat_d = beat_q + LEN_W'(1);
        if (dma_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!dma_req || dma_gnt) begin
      starve_d = '0;
    end else if (core_gnt && !starve_full) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Outputs are forced low while reset is held, even with requests present.
  always_comb begin
    dma_start  = 1'b0;
    dma_err    = 1'b0;
    dma_gnt    = 1'b0;
    core_gnt   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    mem_we     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          dma_err   = dma_req & (dma_addr[1:0] != 2'b00);
          dma_start = dma_req & ~dma_err & (~core_req | starve_full);
          core_gnt  = core_req & ~dma_start;
          if (dma_start) begin
            dma_gnt    = 1'b1;
            mem_addr   = dma_addr;
            mem_wdata  = dma_wdata;
            mem_funct3 = 3'b010;
            mem_we     = dma_we;
          end else if (core_gnt) begin
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
            mem_funct3 = core_funct3;
            mem_we     = core_we;
          end
        end
        StBurst: begin
          dma_gnt    = 1'b1;
          mem_addr   = addr_q;
          mem_wdata  = dma_wdata;
          mem_funct3 = 3'b010;
          mem_we     = we_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      dma_rvalid  <= 1'b0;
      dma_rdata   <= '0;
      dma_done    <= 1'b0;
      starve_q    <= '0;
    end else begin
      core_rvalid <= core_gnt & ~core_we;
      if (core_gnt && !core_we) core_rdata <= mem_rdata;
      dma_rvalid <= dma_gnt & ~mem_we;
      if (dma_gnt && !mem_we) dma_rdata <= mem_rdata;
      dma_done <= (dma_start & (dma_len == '0)) | ((state_q == StBurst) & dma_last);
      starve_q <= starve_d;
    end
  end

endmodule
